// File: rtl/apb_matrix_ctrl_if.sv
// APB3 slave bus bundle for the matrix accelerator controller.
interface apb_matrix_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_matrix_ctrl.sv
// APB3 register front-end sequencing X-buffer load, ALU run and result
// readback for the matrix accelerator datapath.
module apb_matrix_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int LOAD_WORDS     = 8,
  parameter int NUM_CALC       = 16,
  parameter int RD_TIMEOUT     = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  apb_matrix_ctrl_if.slave          apb,
  output logic                      load_en,
  output logic                      valid_input,
  output logic                      ALU_en,
  output logic                      read_n,
  output logic [7:0]                acc_counter,
  output logic [APB_ADDR_WIDTH-1:0] r_addr,
  input  logic                      load_done,
  input  logic                      cal_finish,
  input  logic                      ry,
  input  logic [31:0]               data_out,
  output logic                      irq
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam int CNT_W = $clog2(RD_TIMEOUT + 2);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CTRL   = APB_ADDR_WIDTH'(32'h000);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_STATUS = APB_ADDR_WIDTH'(32'h004);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_XDATA  = APB_ADDR_WIDTH'(32'h008);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_RES_LO = APB_ADDR_WIDTH'(32'h400);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_RES_HI = APB_ADDR_WIDTH'(32'h7FC);

  state_t           state_q, state_d;
  logic             access_q, access_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             pulse_q, pulse_d;
  logic [7:0]       acc_counter_q, acc_counter_d;
  logic [7:0]       calc_cnt_q, calc_cnt_d;
  logic             ld_seen_q, ld_seen_d;
  logic             cal_prev_q, cal_prev_d;

  logic             access;
  logic             sel_ctrl, sel_status, sel_xdata, sel_result;
  logic             rd_result_ok;
  logic             pready, pslverr;
  logic [31:0]      prdata;
  logic             read_n_c;
  logic [APB_ADDR_WIDTH-1:0] r_addr_c;
  logic [7:0]       acc_eff;
  logic [31:0]      status_word;
  logic             wr_ok;
  logic             unused_bits;

  assign unused_bits = ^{apb.PWDATA[31:2], apb.PADDR[1:0]};

  // access_q marks that a setup phase was seen, so only properly framed
  // transfers (never one left dangling across reset) get a response.
  always_comb begin
    access       = access_q && apb.PSEL && apb.PENABLE;
    sel_ctrl     = (apb.PADDR == ADDR_CTRL);
    sel_status   = (apb.PADDR == ADDR_STATUS);
    sel_xdata    = (apb.PADDR == ADDR_XDATA);
    sel_result   = (apb.PADDR >= ADDR_RES_LO) && (apb.PADDR <= ADDR_RES_HI);
    rd_result_ok = access && sel_result && !apb.PWRITE && (state_q == DONE);
    acc_eff      = acc_counter_q + {7'd0, pulse_q};
    status_word  = {8'h00, acc_counter_q, calc_cnt_q, 5'd0, ld_seen_q,
                    state_q == DONE, state_q == RUN};

    pready   = 1'b0;
    pslverr  = 1'b0;
    prdata   = 32'h0;
    read_n_c = 1'b1;
    r_addr_c = '0;

    if (rd_result_ok) begin
      r_addr_c = APB_ADDR_WIDTH'(apb.PADDR[9:2]);
      read_n_c = (rd_cnt_q != '0);
      if (ry) begin
        pready = 1'b1;
        prdata = data_out;
      end else if (rd_cnt_q == CNT_W'(RD_TIMEOUT)) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end
    end else if (access) begin
      pready = 1'b1;
      if (apb.PWRITE) begin
        if (sel_ctrl) begin
          pslverr = !apb.PWDATA[1] && apb.PWDATA[0] &&
                    !((state_q == LOAD) && ld_seen_q);
        end else if (sel_xdata) begin
          pslverr = !(((state_q == IDLE) || (state_q == LOAD)) &&
                      (acc_eff < 8'(LOAD_WORDS)));
        end else begin
          pslverr = 1'b1;
        end
      end else if (sel_status) begin
        prdata = status_word;
      end else begin
        pslverr = 1'b1;
      end
    end

    wr_ok = access && pready && apb.PWRITE && !pslverr;
  end

  // Next-state: datapath events first, then APB writes; clear wins over all.
  always_comb begin
    state_d       = state_q;
    access_d      = access_q;
    rd_cnt_d      = '0;
    pulse_d       = 1'b0;
    acc_counter_d = acc_counter_q;
    calc_cnt_d    = calc_cnt_q;
    ld_seen_d     = ld_seen_q;
    cal_prev_d    = cal_finish;

    if (apb.PSEL && !apb.PENABLE) begin
      access_d = 1'b1;
    end else if (!apb.PSEL || pready) begin
      access_d = 1'b0;
    end

    if (rd_result_ok && !pready) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end

    if (pulse_q) begin
      acc_counter_d = acc_counter_q + 8'd1;
    end

    case (state_q)
      LOAD: begin
        if (load_done) ld_seen_d = 1'b1;
      end
      RUN: begin
        if (cal_finish && !cal_prev_q) begin
          calc_cnt_d = calc_cnt_q + 8'd1;
          if (calc_cnt_q + 8'd1 == 8'(NUM_CALC)) state_d = DONE;
        end
      end
      default: ;
    endcase

    if (wr_ok && sel_ctrl) begin
      if (apb.PWDATA[1]) begin
        state_d       = IDLE;
        acc_counter_d = 8'd0;
        calc_cnt_d    = 8'd0;
        ld_seen_d     = 1'b0;
      end else if (apb.PWDATA[0]) begin
        state_d = RUN;
      end
    end

    if (wr_ok && sel_xdata) begin
      pulse_d = 1'b1;
      state_d = LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      access_q      <= 1'b0;
      rd_cnt_q      <= '0;
      pulse_q       <= 1'b0;
      acc_counter_q <= 8'd0;
      calc_cnt_q    <= 8'd0;
      ld_seen_q     <= 1'b0;
      cal_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      access_q      <= access_d;
      rd_cnt_q      <= rd_cnt_d;
      pulse_q       <= pulse_d;
      acc_counter_q <= acc_counter_d;
      calc_cnt_q    <= calc_cnt_d;
      ld_seen_q     <= ld_seen_d;
      cal_prev_q    <= cal_prev_d;
    end
  end

  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pslverr;
  assign apb.PRDATA  = prdata;
  assign load_en     = pulse_q;
  assign valid_input = pulse_q;
  assign ALU_en      = (state_q == RUN);
  assign irq         = (state_q == DONE);
  assign read_n      = read_n_c;
  assign r_addr      = r_addr_c;
  assign acc_counter = acc_counter_q;

endmodule

// File: tb/tb_apb_matrix_ctrl.sv
// Scoreboard bench for apb_matrix_ctrl: stimulus queues expected APB
// responses and load pulses, monitors pop and compare them.
module tb_apb_matrix_ctrl;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_en, valid_input, ALU_en, read_n, irq;
  logic [7:0]    acc_counter;
  logic [AW-1:0] r_addr;
  logic          load_done = 1'b0;
  logic          cal_finish = 1'b0;
  logic          ry = 1'b0;
  logic [31:0]   data_out = 32'hCAFE_0002;

  apb_matrix_ctrl_if #(.ADDR_W(AW)) apb_bus ();

  apb_matrix_ctrl #(
    .APB_ADDR_WIDTH(AW), .LOAD_WORDS(8), .NUM_CALC(16), .RD_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .apb(apb_bus),
    .load_en(load_en), .valid_input(valid_input), .ALU_en(ALU_en),
    .read_n(read_n), .acc_counter(acc_counter), .r_addr(r_addr),
    .load_done(load_done), .cal_finish(cal_finish), .ry(ry),
    .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] prdata;
    logic        slverr;
  } exp_resp_t;

  exp_resp_t  resp_q[$];
  logic [7:0] pulse_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_resp_t e;
    logic [7:0] exp_acc;
    if (apb_bus.PSEL && apb_bus.PENABLE && apb_bus.PREADY) begin
      if (resp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_response: got PRDATA 0x%08h, expected no transfer",
                 apb_bus.PRDATA);
      end else begin
        e = resp_q.pop_front();
        checkOutput({e.name, " PRDATA"}, apb_bus.PRDATA, e.prdata);
        checkOutput({e.name, " PSLVERR"}, {31'd0, apb_bus.PSLVERR}, {31'd0, e.slverr});
      end
    end
    if (load_en || valid_input) begin
      if (pulse_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_load_pulse: got acc_counter %0d, expected no pulse",
                 acc_counter);
      end else begin
        exp_acc = pulse_q.pop_front();
        checkOutput("load_pulse acc_counter", {24'd0, acc_counter}, {24'd0, exp_acc});
        checkOutput("load_pulse load_en/valid_input", {30'd0, load_en, valid_input}, 32'd3);
      end
    end
  end

  task automatic apbXfer(input string name, input logic wr, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, output int waits, output int rn_low,
                         output logic [AW-1:0] raddr_seen);
    exp_resp_t e;
    logic done;
    e.name = name;
    e.prdata = exp_rdata;
    e.slverr = exp_err;
    resp_q.push_back(e);
    @(posedge clk); #1;
    apb_bus.PSEL = 1'b1; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = wr;
    apb_bus.PADDR = addr; apb_bus.PWDATA = wdata;
    @(posedge clk); #1;
    apb_bus.PENABLE = 1'b1;
    waits = 0; rn_low = 0; raddr_seen = '0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (!read_n) rn_low++;
      if (c == 0) raddr_seen = r_addr;
      if (apb_bus.PREADY) done = 1'b1;
      else waits++;
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s timeout: got PREADY 0 for 64 cycles, expected PREADY 1", name);
    end
    @(posedge clk); #1;
    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b0;
  endtask

  task automatic apbWrite(input string name, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic exp_err);
    int w, r;
    logic [AW-1:0] a;
    apbXfer(name, 1'b1, addr, wdata, 32'h0, exp_err, w, r, a);
  endtask

  task automatic apbRead(input string name, input logic [AW-1:0] addr,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int w, r;
    logic [AW-1:0] a;
    apbXfer(name, 1'b0, addr, 32'h0, exp_rdata, exp_err, w, r, a);
  endtask

  task automatic pulseLoadDone();
    @(posedge clk); #1 load_done = 1'b1;
    @(posedge clk); #1 load_done = 1'b0;
  endtask

  task automatic pulseCalFinish();
    @(posedge clk); #1 cal_finish = 1'b1;
    @(posedge clk); #1 cal_finish = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " PREADY"},  {31'd0, apb_bus.PREADY},  32'd0);
    checkOutput({tag, " PSLVERR"}, {31'd0, apb_bus.PSLVERR}, 32'd0);
    checkOutput({tag, " PRDATA"},  apb_bus.PRDATA, 32'd0);
    checkOutput({tag, " ctrl_outs"},
                {27'd0, load_en, valid_input, ALU_en, read_n, irq}, 32'b00010);
    checkOutput({tag, " acc_counter"}, {24'd0, acc_counter}, 32'd0);
    checkOutput({tag, " r_addr"}, {20'd0, r_addr}, 32'd0);
  endtask

  task automatic applyStimulus();
    int waits, rn_low;
    logic [AW-1:0] ra;

    // Reset with a transfer pending on the bus: no response may leak out.
    apb_bus.PSEL = 1'b1; apb_bus.PENABLE = 1'b1; apb_bus.PWRITE = 1'b0;
    apb_bus.PADDR = 12'h004; apb_bus.PWDATA = 32'h0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    apbRead("status_after_reset", 12'h004, 32'h0, 1'b0);
    apbWrite("start_in_idle", 12'h000, 32'h1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      pulse_q.push_back(8'(i));
      apbWrite("xdata_write", 12'h008, 32'((i + 1) * 32'h11), 1'b0);
    end
    apbWrite("xdata_overflow", 12'h008, 32'h99, 1'b1);
    apbWrite("start_no_load_done", 12'h000, 32'h1, 1'b1);
    pulseCalFinish();
    apbRead("status_loaded", 12'h004, 32'h0008_0000, 1'b0);
    apbRead("result_in_load", 12'h400, 32'h0, 1'b1);
    apbWrite("write_status_ro", 12'h004, 32'hFFFF_FFFF, 1'b1);
    apbRead("reserved_read", 12'h010, 32'h0, 1'b1);

    pulseLoadDone();
    apbWrite("start_ok", 12'h000, 32'h1, 1'b0);
    @(negedge clk);
    checkOutput("alu_en_in_run", {31'd0, ALU_en}, 32'd1);
    apbRead("status_run", 12'h004, 32'h0008_0005, 1'b0);
    apbRead("result_in_run", 12'h404, 32'h0, 1'b1);
    apbRead("status_run_unchanged", 12'h004, 32'h0008_0005, 1'b0);

    for (int i = 0; i < 15; i++) pulseCalFinish();
    @(negedge clk);
    checkOutput("alu_irq_after_15", {30'd0, ALU_en, irq}, 32'b10);
    pulseCalFinish();
    @(negedge clk);
    checkOutput("alu_irq_after_16", {30'd0, ALU_en, irq}, 32'b01);
    apbRead("status_done", 12'h004, 32'h0008_1006, 1'b0);

    fork
      apbXfer("result_read_408", 1'b0, 12'h408, 32'h0, 32'hCAFE_0002, 1'b0,
              waits, rn_low, ra);
      begin
        for (int c = 0; c < 64; c++) begin
          @(negedge clk);
          if (!read_n) break;
        end
        repeat (3) @(posedge clk);
        #1 ry = 1'b1;
        for (int c = 0; c < 64; c++) begin
          @(negedge clk);
          if (apb_bus.PREADY) break;
        end
        @(posedge clk); #1 ry = 1'b0;
      end
    join
    checkOutput("result_read wait_states", 32'(waits), 32'd3);
    checkOutput("result_read read_n_low_cycles", 32'(rn_low), 32'd1);
    checkOutput("result_read r_addr", {20'd0, ra}, 32'd2);

    apbXfer("result_timeout", 1'b0, 12'h400, 32'h0, 32'h0, 1'b1, waits, rn_low, ra);
    checkOutput("result_timeout wait_states", 32'(waits), 32'd15);

    apbWrite("clear_in_done", 12'h000, 32'h2, 1'b0);
    @(negedge clk);
    checkOutput("irq_after_clear", {31'd0, irq}, 32'd0);
    apbRead("status_after_clear", 12'h004, 32'h0, 1'b0);

    pulseLoadDone();
    pulse_q.push_back(8'd0);
    apbWrite("xdata_after_clear", 12'h008, 32'hA5, 1'b0);
    apbWrite("start_idle_load_done_ignored", 12'h000, 32'h1, 1'b1);
    apbRead("status_reload", 12'h004, 32'h0001_0000, 1'b0);
    pulseLoadDone();
    apbWrite("start_ok_2", 12'h000, 32'h1, 1'b0);
    pulseCalFinish();
    pulseCalFinish();
    apbRead("status_run_2", 12'h004, 32'h0001_0205, 1'b0);

    @(posedge clk); #2 rst = 1'b0;
    #1;
    checkResetOutputs("reset_mid_run");
    @(posedge clk); #1 rst = 1'b1;
    apbRead("status_after_reset_2", 12'h004, 32'h0, 1'b0);
  endtask

  initial begin
    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b0;
    apb_bus.PADDR = '0; apb_bus.PWDATA = '0;
    applyStimulus();
    repeat (3) @(negedge clk);
    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    checkOutput("pulse_queue_drained", 32'(pulse_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/apb_matrix_ctrl.md
APB_MATRIX_CTRL -- requirements
Module: apb_matrix_ctrl

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width (4 KB slave window).
REQ-002 SHALL have parameter LOAD_WORDS, default 8, number of 32-bit X words per job.
REQ-003 SHALL have parameter NUM_CALC, default 16, number of cal_finish pulses per job.
REQ-004 SHALL have parameter RD_TIMEOUT, default 15, maximum cycles to wait for ry.
REQ-005 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-006 Port: rst  in  1  reset, asynchronous, active-low.
REQ-007 Port: PSEL, PENABLE, PWRITE  in  1 each  APB3 control.
REQ-008 Port: PADDR  in  APB_ADDR_WIDTH  APB byte address.
REQ-009 Port: PWDATA  in  32  APB write data; also forwarded to the X buffer.
REQ-010 Port: PRDATA  out  32; PREADY  out  1; PSLVERR  out  1  APB response.
REQ-011 Port: load_en, valid_input, ALU_en, read_n  out  1 each  datapath control.
REQ-012 Port: acc_counter  out  8; r_addr  out  APB_ADDR_WIDTH  X word index / result read address.
REQ-013 Port: load_done, cal_finish, ry  in  1 each; data_out  in  32  datapath status and read data.
REQ-014 Port: irq  out  1  level interrupt, high in DONE.

Function
REQ-015 Register map SHALL be: 0x000 CTRL (W: bit0 start, bit1 clear), 0x004 STATUS (R), 0x008 XDATA (W), 0x400-0x7FC RESULT (R); any other address returns PRDATA=0 and PSLVERR=1.
REQ-016 FSM states SHALL be IDLE, LOAD, RUN, DONE; the reset state is IDLE.
REQ-017 IDLE->LOAD SHALL occur on the first accepted XDATA write.
REQ-018 XDATA write in IDLE or LOAD: load_en=1 and valid_input=1 for exactly one cycle after the access phase, acc_counter = number of words previously accepted, then acc_counter increments.
REQ-019 acc_counter SHALL saturate at LOAD_WORDS; further XDATA writes SHALL get PSLVERR=1 with no pulse.
REQ-020 LOAD->RUN SHALL occur on a CTRL.start write once load_done has been seen high; ALU_en=1 throughout RUN.
REQ-021 CTRL.start without load_done seen SHALL get PSLVERR=1 and leave the state unchanged.
REQ-022 In RUN, each cal_finish rising cycle SHALL increment calc_cnt (8 bit); at calc_cnt==NUM_CALC, RUN->DONE, ALU_en=0 the same edge, irq=1.
REQ-023 CTRL.clear in any state SHALL return to IDLE and zero acc_counter, calc_cnt, load_done_seen and irq; it is the only exit from DONE.
REQ-024 STATUS SHALL read bit0 = busy (RUN), bit1 = done (DONE), bit2 = load_done_seen, [15:8] = calc_cnt, [23:16] = acc_counter, others 0.
REQ-025 Register writes and reads SHALL complete with PREADY=1 in the first access cycle (zero wait states).
REQ-026 RESULT read SHALL be allowed only in DONE, otherwise PREADY=1, PSLVERR=1, PRDATA=0.
REQ-027 RESULT read in DONE: r_addr = PADDR[9:2] zero-extended; read_n=0 for exactly the first access cycle; PREADY held 0 until ry=1; then PRDATA = data_out, PREADY=1 in that same cycle.
REQ-028 If ry is not seen within RD_TIMEOUT cycles, PREADY=1 and PSLVERR=1, PRDATA=0.
REQ-029 PSLVERR and PRDATA SHALL be valid only while PREADY=1; otherwise they are 0.
REQ-030 A write to a read-only or reserved address SHALL be ignored with PSLVERR=1.
REQ-031 cal_finish and load_done pulses outside RUN/LOAD respectively SHALL be ignored.

Reset
REQ-032 While rst=0: state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, load_en=0, valid_input=0, ALU_en=0, read_n=1, acc_counter=0, r_addr=0, irq=0, all counters cleared.
REQ-033 Reset asserted mid-transfer or mid-RUN SHALL abort immediately; the first APB access after release SHALL be treated as new.

Verification
REQ-034 8 XDATA writes 0x11..0x88 -> eight 1-cycle load_en/valid_input pulses, acc_counter 0..7; 9th write PSLVERR=1.
REQ-035 load_done pulse, CTRL=0x1, then 16 cal_finish pulses -> ALU_en high 16 pulses, DONE, irq=1, STATUS=0x0008_1006.
REQ-036 In DONE, read 0x408 with ry after 3 cycles -> r_addr=2, read_n low 1 cycle, PREADY after 3 wait states, PRDATA=data_out.
REQ-037 ry never asserted -> PREADY=1, PSLVERR=1 after 15 cycles.
REQ-038 CTRL=0x1 before load_done, and RESULT read in RUN -> PSLVERR=1, state unchanged.
REQ-039 rst low during RUN -> all outputs at reset values; CTRL=0x2 in DONE -> IDLE, irq=0.
